// File: rtl/ctrl_pipe.sv
// Purpose: RV32I(+M) control decoder with ID/EX register, load-use interlock, flush and M-op sequencer.
// Latency: 1 cycle ID->EX; an M op occupies EX for MDU_LAT cycles.
// Backpressure: stall holds PC and IF/ID during load-use bubbles and all but the last cycle of an M op.
module ctrl_pipe #(
  parameter int          ENABLE_M       = 1,
  parameter int unsigned MDU_LAT        = 4,
  parameter int          ENABLE_LOADUSE = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        id_valid,
  input  logic [31:0] id_instr,
  input  logic        flush,
  output logic        stall,
  output logic        ex_valid,
  output logic        ex_RegWrite,
  output logic        ex_MemWrite,
  output logic        ex_ALUSrc,
  output logic [5:0]  ex_EXTOp,
  output logic [4:0]  ex_ALUOp,
  output logic [1:0]  ex_WDSel,
  output logic [2:0]  ex_dm_ctrl,
  output logic        ex_branch,
  output logic        ex_jal,
  output logic        ex_jalr,
  output logic [4:0]  ex_rd,
  output logic        ex_mdu,
  output logic [2:0]  ex_mdu_op,
  output logic        ex_mdu_done,
  output logic        ex_illegal
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [5:0] EXT_SHAMT = 6'b100000;
  localparam logic [5:0] EXT_I     = 6'b010000;
  localparam logic [5:0] EXT_S     = 6'b001000;
  localparam logic [5:0] EXT_B     = 6'b000100;
  localparam logic [5:0] EXT_U     = 6'b000010;
  localparam logic [5:0] EXT_J     = 6'b000001;

  localparam logic [4:0] ALU_LUI   = 5'd1;
  localparam logic [4:0] ALU_AUIPC = 5'd2;
  localparam logic [4:0] ALU_ADD   = 5'd3;
  localparam logic [4:0] ALU_SUB   = 5'd4;
  localparam logic [4:0] ALU_BNE   = 5'd5;
  localparam logic [4:0] ALU_BLT   = 5'd6;
  localparam logic [4:0] ALU_BGE   = 5'd7;
  localparam logic [4:0] ALU_BLTU  = 5'd8;
  localparam logic [4:0] ALU_BGEU  = 5'd9;
  localparam logic [4:0] ALU_SLT   = 5'd10;
  localparam logic [4:0] ALU_SLTU  = 5'd11;
  localparam logic [4:0] ALU_XOR   = 5'd12;
  localparam logic [4:0] ALU_OR    = 5'd13;
  localparam logic [4:0] ALU_AND   = 5'd14;
  localparam logic [4:0] ALU_SLL   = 5'd15;
  localparam logic [4:0] ALU_SRL   = 5'd16;
  localparam logic [4:0] ALU_SRA   = 5'd17;

  localparam logic [2:0] DM_WORD = 3'b000;
  localparam logic [2:0] DM_HALF = 3'b001;
  localparam logic [2:0] DM_HU   = 3'b010;
  localparam logic [2:0] DM_BYTE = 3'b011;
  localparam logic [2:0] DM_BU   = 3'b100;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_write;
    logic       alu_src;
    logic [5:0] ext_op;
    logic [4:0] alu_op;
    logic [1:0] wd_sel;
    logic [2:0] dm_ctrl;
    logic       branch;
    logic       jal;
    logic       jalr;
    logic [4:0] rd;
    logic       mdu;
    logic [2:0] mdu_op;
    logic       illegal;
  } bundle_t;

  typedef enum logic {IDLE, BUSY} state_t;

  bundle_t    dec, ex_cur, ex_nxt;
  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       bad;
  logic       rs1_used, rs2_used, load_use;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] rs1, rs2;

  assign opcode = id_instr[6:0];
  assign f3     = id_instr[14:12];
  assign f7     = id_instr[31:25];
  assign rs1    = id_instr[19:15];
  assign rs2    = id_instr[24:20];

  // Combinational decode of the ID instruction; illegal encodings collapse to a bare illegal flag.
  always_comb begin
    dec       = '0;
    bad       = 1'b0;
    dec.valid = 1'b1;
    case (opcode)
      OP_R: begin
        if (ENABLE_M != 0 && f7 == 7'b0000001) begin
          dec.reg_write = 1'b1;
          dec.mdu       = 1'b1;
          dec.mdu_op    = f3;
        end else if (f7 == 7'b0000000 || f7 == 7'b0100000) begin
          dec.reg_write = 1'b1;
          case (f3)
            3'b000:  dec.alu_op = f7[5] ? ALU_SUB : ALU_ADD;
            3'b001:  dec.alu_op = ALU_SLL;
            3'b010:  dec.alu_op = ALU_SLT;
            3'b011:  dec.alu_op = ALU_SLTU;
            3'b100:  dec.alu_op = ALU_XOR;
            3'b101:  dec.alu_op = f7[5] ? ALU_SRA : ALU_SRL;
            3'b110:  dec.alu_op = ALU_OR;
            default: dec.alu_op = ALU_AND;
          endcase
        end else begin
          bad = 1'b1;
        end
      end
      OP_I: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.ext_op    = EXT_I;
        case (f3)
          3'b000: dec.alu_op = ALU_ADD;
          3'b010: dec.alu_op = ALU_SLT;
          3'b011: dec.alu_op = ALU_SLTU;
          3'b100: dec.alu_op = ALU_XOR;
          3'b110: dec.alu_op = ALU_OR;
          3'b111: dec.alu_op = ALU_AND;
          3'b001: begin
            dec.ext_op = EXT_SHAMT;
            dec.alu_op = ALU_SLL;
            bad        = (f7 != 7'b0000000);
          end
          default: begin
            dec.ext_op = EXT_SHAMT;
            dec.alu_op = f7[5] ? ALU_SRA : ALU_SRL;
            bad        = (f7 != 7'b0000000) && (f7 != 7'b0100000);
          end
        endcase
      end
      OP_LD: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.ext_op    = EXT_I;
        dec.alu_op    = ALU_ADD;
        dec.wd_sel    = 2'b01;
        case (f3)
          3'b000:  dec.dm_ctrl = DM_BYTE;
          3'b001:  dec.dm_ctrl = DM_HALF;
          3'b100:  dec.dm_ctrl = DM_BU;
          3'b101:  dec.dm_ctrl = DM_HU;
          default: dec.dm_ctrl = DM_WORD;
        endcase
      end
      OP_ST: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.ext_op    = EXT_S;
        dec.alu_op    = ALU_ADD;
        case (f3)
          3'b000:  dec.dm_ctrl = DM_BYTE;
          3'b001:  dec.dm_ctrl = DM_HALF;
          default: dec.dm_ctrl = DM_WORD;
        endcase
      end
      OP_BR: begin
        dec.ext_op = EXT_B;
        dec.branch = 1'b1;
        case (f3)
          3'b001:  dec.alu_op = ALU_BNE;
          3'b100:  dec.alu_op = ALU_BLT;
          3'b101:  dec.alu_op = ALU_BGE;
          3'b110:  dec.alu_op = ALU_BLTU;
          3'b111:  dec.alu_op = ALU_BGEU;
          default: dec.alu_op = ALU_SUB;
        endcase
      end
      OP_JAL: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.ext_op    = EXT_J;
        dec.alu_op    = ALU_ADD;
        dec.wd_sel    = 2'b10;
        dec.jal       = 1'b1;
      end
      OP_JALR: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.ext_op    = EXT_I;
        dec.alu_op    = ALU_ADD;
        dec.wd_sel    = 2'b10;
        dec.jalr      = 1'b1;
      end
      OP_LUI: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.ext_op    = EXT_U;
        dec.alu_op    = ALU_LUI;
      end
      OP_AUIPC: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.ext_op    = EXT_U;
        dec.alu_op    = ALU_AUIPC;
      end
      default: bad = 1'b1;
    endcase
    // rd is only meaningful for writers; zero keeps stores/branches out of the hazard compare.
    dec.rd = dec.reg_write ? id_instr[11:7] : 5'd0;
    if (bad) begin
      dec         = '0;
      dec.valid   = 1'b1;
      dec.illegal = 1'b1;
    end
  end

  // Load-use detection against the load currently sitting in EX.
  always_comb begin
    rs1_used = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
    rs2_used = (opcode == OP_R) || (opcode == OP_ST) || (opcode == OP_BR);
    load_use = (ENABLE_LOADUSE != 0) && ex_cur.valid && (ex_cur.wd_sel == 2'b01) &&
               (ex_cur.rd != 5'd0) && id_valid &&
               ((rs1_used && rs1 == ex_cur.rd) || (rs2_used && rs2 == ex_cur.rd));
  end

  // Next EX contents, sequencer state and stall: flush > M-op hold > load-use bubble > advance.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ex_nxt    = ex_cur;
    stall     = 1'b0;
    if (flush) begin
      ex_nxt    = '0;
      state_nxt = IDLE;
      cnt_nxt   = 4'd0;
    end else if (state == BUSY) begin
      stall   = 1'b1;
      cnt_nxt = cnt - 4'd1;
      if (cnt == 4'd1) state_nxt = IDLE;
    end else if (load_use) begin
      stall  = 1'b1;
      ex_nxt = '0;
    end else if (id_valid) begin
      ex_nxt = dec;
      // The last cycle of an M op runs in IDLE so the next instruction advances on its edge.
      if (dec.mdu && MDU_LAT > 1) begin
        state_nxt = BUSY;
        cnt_nxt   = 4'(MDU_LAT - 1);
      end
    end else begin
      ex_nxt = '0;
    end
  end

  // ID/EX register and sequencer state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ex_cur <= '0;
      state  <= IDLE;
      cnt    <= 4'd0;
    end else begin
      ex_cur <= ex_nxt;
      state  <= state_nxt;
      cnt    <= cnt_nxt;
    end
  end

  assign ex_valid    = ex_cur.valid;
  assign ex_RegWrite = ex_cur.reg_write;
  assign ex_MemWrite = ex_cur.mem_write;
  assign ex_ALUSrc   = ex_cur.alu_src;
  assign ex_EXTOp    = ex_cur.ext_op;
  assign ex_ALUOp    = ex_cur.alu_op;
  assign ex_WDSel    = ex_cur.wd_sel;
  assign ex_dm_ctrl  = ex_cur.dm_ctrl;
  assign ex_branch   = ex_cur.branch;
  assign ex_jal      = ex_cur.jal;
  assign ex_jalr     = ex_cur.jalr;
  assign ex_rd       = ex_cur.rd;
  assign ex_mdu      = ex_cur.mdu;
  assign ex_mdu_op   = ex_cur.mdu_op;
  assign ex_illegal  = ex_cur.illegal;
  assign ex_mdu_done = ex_cur.mdu && (state == IDLE);

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: directed scenarios, then random instruction streams against a reference model.
// Model tracks EX contents as a bundle plus remaining M-op cycles.
// Front end is emulated: the ID instruction is held whenever the model predicts a stall.
module tb_ctrl_pipe;
  localparam int LAT = 4;

  localparam logic [6:0] R = 7'h33, I = 7'h13, LD = 7'h03, ST = 7'h23, BR = 7'h63;
  localparam logic [6:0] JAL = 7'h6F, JALR = 7'h67, LUI = 7'h37, AUI = 7'h17;
  localparam logic [5:0] EI = 6'b010000, ES = 6'b001000, EB = 6'b000100;
  localparam logic [5:0] EU = 6'b000010, EJ = 6'b000001, ESH = 6'b100000;

  localparam logic [31:0] ADD3 = 32'h002081B3, SUB3 = 32'h402081B3, LW5 = 32'h0000A283;
  localparam logic [31:0] ADD6 = 32'h00228333, ADD8 = 32'h00238433, LW0 = 32'h0000A003;
  localparam logic [31:0] ADDX0 = 32'h00000333, MUL4 = 32'h02208233;

  typedef struct packed {
    logic       valid, rw, mw, asrc;
    logic [5:0] ext;
    logic [4:0] alu;
    logic [1:0] wd;
    logic [2:0] dm;
    logic       br, jl, jr;
    logic [4:0] rd;
    logic       mdu;
    logic [2:0] mop;
    logic       ill;
  } bun_t;

  typedef struct packed {
    logic [6:0] opc;
    logic [2:0] f3;
    logic       f3fix;
    logic [6:0] f7;
    logic       f7fix;
    logic [2:0] wen;
    logic [5:0] ext;
    logic [4:0] alu;
    logic [1:0] wd;
    logic [2:0] dm;
    logic [2:0] bjr;
    logic       mdu;
    logic       ill;
  } op_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn, id_valid, flush;
  logic [31:0] id_instr;
  logic        stall, ex_valid, ex_RegWrite, ex_MemWrite, ex_ALUSrc, ex_branch, ex_jal, ex_jalr;
  logic        ex_mdu, ex_mdu_done, ex_illegal;
  logic [5:0]  ex_EXTOp;
  logic [4:0]  ex_ALUOp, ex_rd;
  logic [1:0]  ex_WDSel;
  logic [2:0]  ex_dm_ctrl, ex_mdu_op;
  logic        nm_stall, nm_valid, nm_RegWrite, nm_MemWrite, nm_ALUSrc, nm_branch, nm_jal, nm_jalr;
  logic        nm_mdu, nm_mdu_done, nm_illegal;
  logic [5:0]  nm_EXTOp;
  logic [4:0]  nm_ALUOp, nm_rd;
  logic [1:0]  nm_WDSel;
  logic [2:0]  nm_dm_ctrl, nm_mdu_op;

  ctrl_pipe #(.ENABLE_M(1), .MDU_LAT(LAT), .ENABLE_LOADUSE(1)) u_dut (
    .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_instr(id_instr), .flush(flush),
    .stall(stall), .ex_valid(ex_valid), .ex_RegWrite(ex_RegWrite), .ex_MemWrite(ex_MemWrite),
    .ex_ALUSrc(ex_ALUSrc), .ex_EXTOp(ex_EXTOp), .ex_ALUOp(ex_ALUOp), .ex_WDSel(ex_WDSel),
    .ex_dm_ctrl(ex_dm_ctrl), .ex_branch(ex_branch), .ex_jal(ex_jal), .ex_jalr(ex_jalr),
    .ex_rd(ex_rd), .ex_mdu(ex_mdu), .ex_mdu_op(ex_mdu_op), .ex_mdu_done(ex_mdu_done),
    .ex_illegal(ex_illegal)
  );

  ctrl_pipe #(.ENABLE_M(0), .MDU_LAT(LAT), .ENABLE_LOADUSE(1)) u_dut_nm (
    .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_instr(id_instr), .flush(flush),
    .stall(nm_stall), .ex_valid(nm_valid), .ex_RegWrite(nm_RegWrite), .ex_MemWrite(nm_MemWrite),
    .ex_ALUSrc(nm_ALUSrc), .ex_EXTOp(nm_EXTOp), .ex_ALUOp(nm_ALUOp), .ex_WDSel(nm_WDSel),
    .ex_dm_ctrl(nm_dm_ctrl), .ex_branch(nm_branch), .ex_jal(nm_jal), .ex_jalr(nm_jalr),
    .ex_rd(nm_rd), .ex_mdu(nm_mdu), .ex_mdu_op(nm_mdu_op), .ex_mdu_done(nm_mdu_done),
    .ex_illegal(nm_illegal)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bun_t obs();
    bun_t b;
    b = {ex_valid, ex_RegWrite, ex_MemWrite, ex_ALUSrc, ex_EXTOp, ex_ALUOp, ex_WDSel, ex_dm_ctrl,
         ex_branch, ex_jal, ex_jalr, ex_rd, ex_mdu, ex_mdu_op, ex_illegal};
    return b;
  endfunction

  function automatic op_t mk(logic [6:0] opc, logic [2:0] f3, logic f3fix, logic [6:0] f7,
                             logic f7fix, logic [2:0] wen, logic [5:0] ext, logic [4:0] alu,
                             logic [1:0] wd, logic [2:0] dm, logic [2:0] bjr, logic mdu, logic ill);
    op_t o;
    o = {opc, f3, f3fix, f7, f7fix, wen, ext, alu, wd, dm, bjr, mdu, ill};
    return o;
  endfunction

  // Instruction catalogue: encoding template and the control bundle each mnemonic must produce.
  function automatic op_t op_at(int k);
    op_t o;
    case (k)
      0:  o = mk(R, 3'd0, 1, 7'h00, 1, 3'b100, 6'd0, 5'd3, 2'd0, 3'd0, 3'b000, 0, 0);
      1:  o = mk(R, 3'd0, 1, 7'h20, 1, 3'b100, 6'd0, 5'd4, 2'd0, 3'd0, 3'b000, 0, 0);
      2:  o = mk(R, 3'd1, 1, 7'h00, 1, 3'b100, 6'd0, 5'd15, 2'd0, 3'd0, 3'b000, 0, 0);
      3:  o = mk(R, 3'd2, 1, 7'h00, 1, 3'b100, 6'd0, 5'd10, 2'd0, 3'd0, 3'b000, 0, 0);
      4:  o = mk(R, 3'd3, 1, 7'h00, 1, 3'b100, 6'd0, 5'd11, 2'd0, 3'd0, 3'b000, 0, 0);
      5:  o = mk(R, 3'd4, 1, 7'h00, 1, 3'b100, 6'd0, 5'd12, 2'd0, 3'd0, 3'b000, 0, 0);
      6:  o = mk(R, 3'd5, 1, 7'h00, 1, 3'b100, 6'd0, 5'd16, 2'd0, 3'd0, 3'b000, 0, 0);
      7:  o = mk(R, 3'd5, 1, 7'h20, 1, 3'b100, 6'd0, 5'd17, 2'd0, 3'd0, 3'b000, 0, 0);
      8:  o = mk(R, 3'd6, 1, 7'h00, 1, 3'b100, 6'd0, 5'd13, 2'd0, 3'd0, 3'b000, 0, 0);
      9:  o = mk(R, 3'd7, 1, 7'h00, 1, 3'b100, 6'd0, 5'd14, 2'd0, 3'd0, 3'b000, 0, 0);
      10: o = mk(I, 3'd0, 1, 7'h00, 0, 3'b101, EI, 5'd3, 2'd0, 3'd0, 3'b000, 0, 0);
      11: o = mk(I, 3'd2, 1, 7'h00, 0, 3'b101, EI, 5'd10, 2'd0, 3'd0, 3'b000, 0, 0);
      12: o = mk(I, 3'd3, 1, 7'h00, 0, 3'b101, EI, 5'd11, 2'd0, 3'd0, 3'b000, 0, 0);
      13: o = mk(I, 3'd4, 1, 7'h00, 0, 3'b101, EI, 5'd12, 2'd0, 3'd0, 3'b000, 0, 0);
      14: o = mk(I, 3'd6, 1, 7'h00, 0, 3'b101, EI, 5'd13, 2'd0, 3'd0, 3'b000, 0, 0);
      15: o = mk(I, 3'd7, 1, 7'h00, 0, 3'b101, EI, 5'd14, 2'd0, 3'd0, 3'b000, 0, 0);
      16: o = mk(I, 3'd1, 1, 7'h00, 1, 3'b101, ESH, 5'd15, 2'd0, 3'd0, 3'b000, 0, 0);
      17: o = mk(I, 3'd5, 1, 7'h00, 1, 3'b101, ESH, 5'd16, 2'd0, 3'd0, 3'b000, 0, 0);
      18: o = mk(I, 3'd5, 1, 7'h20, 1, 3'b101, ESH, 5'd17, 2'd0, 3'd0, 3'b000, 0, 0);
      19: o = mk(LD, 3'd0, 1, 7'h00, 0, 3'b101, EI, 5'd3, 2'd1, 3'd3, 3'b000, 0, 0);
      20: o = mk(LD, 3'd1, 1, 7'h00, 0, 3'b101, EI, 5'd3, 2'd1, 3'd1, 3'b000, 0, 0);
      21: o = mk(LD, 3'd2, 1, 7'h00, 0, 3'b101, EI, 5'd3, 2'd1, 3'd0, 3'b000, 0, 0);
      22: o = mk(LD, 3'd4, 1, 7'h00, 0, 3'b101, EI, 5'd3, 2'd1, 3'd4, 3'b000, 0, 0);
      23: o = mk(LD, 3'd5, 1, 7'h00, 0, 3'b101, EI, 5'd3, 2'd1, 3'd2, 3'b000, 0, 0);
      24: o = mk(ST, 3'd0, 1, 7'h00, 0, 3'b011, ES, 5'd3, 2'd0, 3'd3, 3'b000, 0, 0);
      25: o = mk(ST, 3'd1, 1, 7'h00, 0, 3'b011, ES, 5'd3, 2'd0, 3'd1, 3'b000, 0, 0);
      26: o = mk(ST, 3'd2, 1, 7'h00, 0, 3'b011, ES, 5'd3, 2'd0, 3'd0, 3'b000, 0, 0);
      27: o = mk(BR, 3'd0, 1, 7'h00, 0, 3'b000, EB, 5'd4, 2'd0, 3'd0, 3'b100, 0, 0);
      28: o = mk(BR, 3'd1, 1, 7'h00, 0, 3'b000, EB, 5'd5, 2'd0, 3'd0, 3'b100, 0, 0);
      29: o = mk(BR, 3'd4, 1, 7'h00, 0, 3'b000, EB, 5'd6, 2'd0, 3'd0, 3'b100, 0, 0);
      30: o = mk(BR, 3'd5, 1, 7'h00, 0, 3'b000, EB, 5'd7, 2'd0, 3'd0, 3'b100, 0, 0);
      31: o = mk(BR, 3'd6, 1, 7'h00, 0, 3'b000, EB, 5'd8, 2'd0, 3'd0, 3'b100, 0, 0);
      32: o = mk(BR, 3'd7, 1, 7'h00, 0, 3'b000, EB, 5'd9, 2'd0, 3'd0, 3'b100, 0, 0);
      33: o = mk(JAL, 3'd0, 0, 7'h00, 0, 3'b101, EJ, 5'd3, 2'd2, 3'd0, 3'b010, 0, 0);
      34: o = mk(JALR, 3'd0, 1, 7'h00, 0, 3'b101, EI, 5'd3, 2'd2, 3'd0, 3'b001, 0, 0);
      35: o = mk(LUI, 3'd0, 0, 7'h00, 0, 3'b101, EU, 5'd1, 2'd0, 3'd0, 3'b000, 0, 0);
      36: o = mk(AUI, 3'd0, 0, 7'h00, 0, 3'b101, EU, 5'd2, 2'd0, 3'd0, 3'b000, 0, 0);
      37: o = mk(R, 3'd0, 0, 7'h01, 1, 3'b100, 6'd0, 5'd0, 2'd0, 3'd0, 3'b000, 1, 0);
      38: o = mk(7'h0F, 3'd0, 0, 7'h00, 0, 3'b000, 6'd0, 5'd0, 2'd0, 3'd0, 3'b000, 0, 1);
      39: o = mk(7'h73, 3'd0, 0, 7'h00, 0, 3'b000, 6'd0, 5'd0, 2'd0, 3'd0, 3'b000, 0, 1);
      40: o = mk(R, 3'd0, 0, 7'h02, 1, 3'b000, 6'd0, 5'd0, 2'd0, 3'd0, 3'b000, 0, 1);
      41: o = mk(I, 3'd1, 1, 7'h20, 1, 3'b000, 6'd0, 5'd0, 2'd0, 3'd0, 3'b000, 0, 1);
      default: o = mk(I, 3'd5, 1, 7'h04, 1, 3'b000, 6'd0, 5'd0, 2'd0, 3'd0, 3'b000, 0, 1);
    endcase
    return o;
  endfunction

  function automatic bun_t expect_of(op_t o, logic [31:0] ins);
    bun_t b;
    b = '0;
    b.valid = 1'b1;
    if (o.ill) begin
      b.ill = 1'b1;
    end else begin
      {b.rw, b.mw, b.asrc} = o.wen;
      b.ext = o.ext;
      b.alu = o.alu;
      b.wd  = o.wd;
      b.dm  = o.dm;
      {b.br, b.jl, b.jr} = o.bjr;
      b.rd  = o.wen[2] ? ins[11:7] : 5'd0;
      b.mdu = o.mdu;
      b.mop = o.mdu ? ins[14:12] : 3'd0;
    end
    return b;
  endfunction

  task automatic fetch(output logic v, output logic [31:0] ins, output op_t o);
    int k;
    k = $urandom_range(0, 42);
    if ($urandom_range(0, 5) == 0) k = 21;
    o = op_at(k);
    ins = {o.f7fix ? o.f7 : 7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           o.f3fix ? o.f3 : 3'($urandom), 5'($urandom_range(0, 3)), o.opc};
    v = ($urandom_range(0, 6) != 0);
  endtask

  // One M op issued from ID, followed by add x3 held behind it.
  task automatic mdu_seq(input string tag, input bit with_nm);
    id_valid = 1'b1; id_instr = MUL4; flush = 1'b0;
    #1;
    check_eq({tag, "_issue_stall"}, stall, 0);
    tick();
    id_instr = ADD3;
    for (int k = 1; k <= LAT; k++) begin
      #1;
      check_eq($sformatf("%s_mdu_c%0d", tag, k), {ex_valid, ex_mdu, ex_mdu_op}, {1'b1, 1'b1, 3'd0});
      check_eq($sformatf("%s_stall_c%0d", tag, k), stall, (k < LAT));
      check_eq($sformatf("%s_done_c%0d", tag, k), ex_mdu_done, (k == LAT));
      if (with_nm && k == 1) begin
        check_eq("nm_illegal", {nm_valid, nm_illegal}, 2'b11);
        check_eq("nm_regwrite", nm_RegWrite, 0);
        check_eq("nm_mdu", nm_mdu, 0);
        check_eq("nm_stall", nm_stall, 0);
      end
      tick();
    end
    id_valid = 1'b0;
    #1;
    check_eq({tag, "_next"}, {ex_valid, ex_mdu, ex_rd}, {1'b1, 1'b0, 5'd3});
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        fv, fl, haz, busy, e_stall, e_done;
    logic [31:0] fi;
    op_t         fo;
    bun_t        m_ex;
    int          m_rem;

    rstn = 1'b0; id_valid = 1'b0; id_instr = 32'h0; flush = 1'b0;
    #3;
    check_eq("rst_bundle", 64'(obs()), 0);
    check_eq("rst_stall_done", {stall, ex_mdu_done}, 2'b00);
    @(negedge clk); rstn = 1'b1;

    // add / sub / load-use / x0 cases
    id_valid = 1'b1; id_instr = ADD3;
    #1; check_eq("add_issue_stall", stall, 0);
    tick(); id_instr = SUB3; #1;
    check_eq("add_fields", {ex_valid, ex_RegWrite, ex_ALUOp, ex_rd}, {1'b1, 1'b1, 5'b00011, 5'd3});
    check_eq("add_stall", stall, 0);
    tick(); id_instr = LW5; #1;
    check_eq("sub_alu", ex_ALUOp, 5'b00100);
    tick(); id_instr = ADD6; #1;
    check_eq("lw_fields", {ex_WDSel, ex_EXTOp, ex_dm_ctrl, ex_rd}, {2'b01, 6'b010000, 3'b000, 5'd5});
    check_eq("lu_stall", stall, 1);
    tick(); #1;
    check_eq("lu_bubble", ex_valid, 0);
    check_eq("lu_stall_once", stall, 0);
    tick(); id_instr = LW5; #1;
    check_eq("lu_after", {ex_valid, ex_rd}, {1'b1, 5'd6});
    tick(); id_instr = ADD8; #1;
    check_eq("nouse_stall", stall, 0);
    tick(); id_instr = LW0; #1;
    tick(); id_instr = ADDX0; #1;
    check_eq("lw_x0_in_ex", {ex_valid, ex_WDSel}, {1'b1, 2'b01});
    check_eq("lw_x0_stall", stall, 0);
    tick(); id_valid = 1'b0; #1;
    tick();

    mdu_seq("mul", 1'b1);

    // flush in the second BUSY cycle
    id_valid = 1'b1; id_instr = MUL4; #1;
    tick(); id_valid = 1'b0; #1;
    check_eq("fl_c1_stall", stall, 1);
    tick(); flush = 1'b1; #1;
    check_eq("fl_c2_stall", stall, 0);
    check_eq("fl_c2_done", ex_mdu_done, 0);
    tick(); flush = 1'b0; #1;
    check_eq("fl_after", {ex_valid, stall, ex_mdu_done}, 3'b000);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq($sformatf("fl_nodone_%0d", k), {ex_mdu_done, stall}, 2'b00);
    end
    mdu_seq("post_flush", 1'b0);

    // flush coincident with a load-use hazard
    id_valid = 1'b1; id_instr = LW5; #1;
    tick(); id_instr = ADD6; flush = 1'b1; #1;
    check_eq("fl_lu_stall", stall, 0);
    tick(); flush = 1'b0; id_valid = 1'b0; #1;
    check_eq("fl_lu_bubble", ex_valid, 0);
    tick();

    // asynchronous reset in the middle of an M op
    id_valid = 1'b1; id_instr = MUL4; #1;
    tick(); id_valid = 1'b0; #1;
    tick();
    rstn = 1'b0; #1;
    check_eq("rst_mid_bundle", 64'(obs()), 0);
    check_eq("rst_mid_stall_done", {stall, ex_mdu_done}, 2'b00);
    @(negedge clk); @(negedge clk); rstn = 1'b1;
    #1;
    mdu_seq("post_rst", 1'b0);

    // randomized streams against the model
    rstn = 1'b0; #1;
    @(negedge clk); rstn = 1'b1;
    m_ex = '0; m_rem = 0;
    fetch(fv, fi, fo);
    for (int c = 0; c < 3000; c++) begin
      fl = ($urandom_range(0, 11) == 0);
      id_valid = fv; id_instr = fi; flush = fl;
      #1;
      haz = m_ex.valid && m_ex.wd == 2'b01 && m_ex.rd != 5'd0 && fv &&
            ((!(fo.opc == LUI || fo.opc == AUI || fo.opc == JAL) && fi[19:15] == m_ex.rd) ||
             ((fo.opc == R || fo.opc == ST || fo.opc == BR) && fi[24:20] == m_ex.rd));
      busy    = m_ex.mdu && m_rem > 1;
      e_stall = !fl && (busy || haz);
      e_done  = m_ex.mdu && m_rem == 1;
      check_eq("r_bundle", 64'(obs()), 64'(m_ex));
      check_eq("r_stall", stall, e_stall);
      check_eq("r_done", ex_mdu_done, e_done);
      if (fl) begin
        m_ex = '0; m_rem = 0;
      end else if (busy) begin
        m_rem--;
      end else if (haz) begin
        m_ex = '0; m_rem = 0;
      end else if (fv) begin
        m_ex  = expect_of(fo, fi);
        m_rem = m_ex.mdu ? LAT : 0;
      end else begin
        m_ex = '0; m_rem = 0;
      end
      tick();
      if (fl || !e_stall) fetch(fv, fi, fo);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
